// File: rtl/hazard_unit_pkg.sv
// Shared ID-stage pipeline-control codes: forwarding selects, hazard causes
// and the interlock state encoding.
package hazard_unit_pkg;

  localparam int RN_W = 5;

  typedef enum logic [1:0] {
    FW_NONE = 2'd0,
    FW_EX   = 2'd1,
    FW_MEM  = 2'd2,
    FW_WB   = 2'd3
  } fw_sel_e;

  // 2'd3 is reserved for a future cause
  typedef enum logic [1:0] {
    HZ_NONE   = 2'd0,
    HZ_LOAD   = 2'd1,
    HZ_MULDIV = 2'd2
  } hz_cause_e;

  typedef enum logic {
    HZ_IDLE    = 1'b0,
    HZ_MD_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_unit_rn_match.sv
// Flags when one ID source operand reads the register a load in EX is about
// to write; r0 is hard-wired to zero and never matches.
module hz_rn_match
  import hazard_unit_pkg::*;
(
  input  logic [RN_W-1:0] rn,
  input  logic            use_rn,
  input  logic [RN_W-1:0] ex_wr_rn,
  input  logic            ex_we,
  input  logic            ex_load,
  output logic            match
);

  assign match = ex_load & ex_we & (ex_wr_rn != '0) & use_rn & (rn == ex_wr_rn);

endmodule

// File: rtl/hazard_unit.sv
// ID-stage interlock: load-use and mult/div occupancy stalls, with a
// saturating stall-cycle counter for performance monitoring.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MULDIV_CYCLES = 33,
  parameter int CNT_W         = 6,
  parameter int PERF_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RN_W-1:0]   id_rs_rn,
  input  logic [RN_W-1:0]   id_rt_rn,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_rd_hilo,
  input  logic              id_muldiv_start,
  input  logic              ex_load,
  input  logic              ex_we,
  input  logic [RN_W-1:0]   ex_wr_rn,
  input  logic              flush,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_bubble,
  output logic              muldiv_busy,
  output logic [1:0]        hz_cause,
  output logic [PERF_W-1:0] stall_cycles
);

  hz_state_e        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             rs_match, rt_match;
  logic             ld_hz, md_hz, stall;

  hz_rn_match u_rs_match (
    .rn       (id_rs_rn),
    .use_rn   (id_use_rs),
    .ex_wr_rn (ex_wr_rn),
    .ex_we    (ex_we),
    .ex_load  (ex_load),
    .match    (rs_match)
  );

  hz_rn_match u_rt_match (
    .rn       (id_rt_rn),
    .use_rn   (id_use_rt),
    .ex_wr_rn (ex_wr_rn),
    .ex_we    (ex_we),
    .ex_load  (ex_load),
    .match    (rt_match)
  );

  assign muldiv_busy = (state == HZ_MD_BUSY);
  assign ld_hz       = rs_match | rt_match;
  assign md_hz       = muldiv_busy & (id_rd_hilo | id_muldiv_start);
  assign stall       = ~rst & ~flush & (ld_hz | md_hz);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HZ_IDLE;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      HZ_IDLE: begin
        // A start that is itself stalled or killed is retried later
        if (id_muldiv_start && !stall && !flush) begin
          state_next = HZ_MD_BUSY;
          cnt_next   = CNT_W'(MULDIV_CYCLES);
        end
      end
      HZ_MD_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_next = HZ_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = HZ_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    hz_cause     = HZ_NONE;
    if (!rst) begin
      pc_stall     = stall;
      if_id_stall  = stall;
      id_ex_bubble = stall | flush;
      if (flush)      hz_cause = HZ_NONE;
      else if (ld_hz) hz_cause = HZ_LOAD;
      else if (md_hz) hz_cause = HZ_MULDIV;
    end
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline interlock unit that sits in the ID stage, next to the forwarding unit.
- Detects hazards that forwarding cannot cover:
  - load-use on the ID source registers;
  - HI/LO reads or a new mult/div issued while the iterative mult/div unit is still running.
- Drives the PC/IF-ID hold and ID/EX bubble controls.
- Tracks mult/div occupancy with a down-counter and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- MULDIV_CYCLES, 33, number of cycles the mult/div unit stays busy after a start is accepted (must be >= 1).
- CNT_W, 6, width of the busy counter; must satisfy 2^CNT_W > MULDIV_CYCLES.
- PERF_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs_rn  in  5  rs register number of the instruction in ID.
- id_rt_rn  in  5  rt register number of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_rd_hilo  in  1  ID instruction is mfhi/mflo.
- id_muldiv_start  in  1  ID instruction is mult/multu/div/divu.
- ex_load  in  1  EX instruction is a load.
- ex_we  in  1  EX instruction writes the register file.
- ex_wr_rn  in  5  EX destination register number.
- flush  in  1  redirect/exception; the ID instruction is killed this cycle.
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  hold the IF/ID register.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- muldiv_busy  out  1  mult/div unit occupied.
- hz_cause  out  2  cause of the current stall (package codes).
- stall_cycles  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: busy counter = 0, state = IDLE, stall_cycles = 0. While rst = 1, all stall outputs are forced to 0 and hz_cause = HZ_NONE.
- Load-use detection: ld_hz = ex_load & ex_we & (ex_wr_rn != 0) & ((id_use_rs & id_rs_rn == ex_wr_rn) | (id_use_rt & id_rt_rn == ex_wr_rn)).
  - This is combinational, with zero-cycle latency.
  - One stall cycle is sufficient: the next cycle the load is in MEM and the forwarding unit supplies FW_MEM.
- HI/LO and mult/div detection: md_hz = muldiv_busy & (id_rd_hilo | id_muldiv_start).
- Stall outputs: stall = ~flush & (ld_hz | md_hz).
  - pc_stall = if_id_stall = stall.
  - id_ex_bubble = stall | flush.
- hz_cause priority: flush -> HZ_NONE; else ld_hz -> HZ_LOAD; else md_hz -> HZ_MULDIV; else HZ_NONE.
- State machine:
  - IDLE -> MD_BUSY when id_muldiv_start & ~stall & ~flush & ~rst. The counter loads MULDIV_CYCLES.
  - MD_BUSY: the counter decrements every cycle. On the cycle the counter is 1, the next state is IDLE with counter 0.
  - A start while in MD_BUSY does not restart the counter; it stalls instead (md_hz).
- muldiv_busy = (state == MD_BUSY), taken from the registered state. If the start is accepted at edge N, busy is high for exactly MULDIV_CYCLES cycles after N.
- A start that coincides with ld_hz is not accepted. It is re-evaluated when the stall clears.
- flush has no effect on an in-progress mult/div; the counter continues.
- stall_cycles increments by 1 on each edge where stall = 1. It saturates at all-ones and never wraps.
- Reset mid-operation returns to IDLE and clears the counter immediately, regardless of remaining cycles.
- Register number 0 never creates a load-use hazard.

Decomposition:
- Shared package (same header as FW_* codes):
  - HZ_NONE = 2'd0, HZ_LOAD = 2'd1, HZ_MULDIV = 2'd2 (2'd3 reserved);
  - state encodings HZ_IDLE, HZ_MD_BUSY.
- One natural sub-module, hz_rn_match. It takes a register number, a use flag, ex_wr_rn, ex_we and ex_load, and outputs a match bit. It is instantiated twice, for rs and rt.
- The counter and the FSM stay in hazard_unit.

Test Plan:
- Load-use on rs: ex_load = 1, ex_we = 1, ex_wr_rn = 8, id_use_rs = 1, id_rs_rn = 8 -> pc_stall = if_id_stall = id_ex_bubble = 1 and hz_cause = HZ_LOAD for one cycle. With ex_load = 0 the next cycle -> all stall outputs 0 and stall_cycles = 1.
- r0 and unused operands: ex_wr_rn = 0 with id_rs_rn = 0, and separately ex_wr_rn = 9 with id_rt_rn = 9 but id_use_rt = 0 -> no stall.
- Mult/div occupancy: id_muldiv_start = 1 accepted at edge N, MULDIV_CYCLES = 33 -> muldiv_busy high for cycles N+1..N+33. An mflo held in ID stalls for those 33 cycles and proceeds at N+34 with stall_cycles = 33.
- Back-to-back start: a second mult in ID while busy with 5 cycles remaining -> 5 stall cycles, then accepted, and busy holds for a fresh 33 cycles.
- Flush priority: ld_hz conditions together with flush = 1 -> pc_stall = 0, id_ex_bubble = 1, hz_cause = HZ_NONE. A start with flush = 1 is not accepted and busy stays 0.
- Reset mid-operation and saturation:
  - rst = 1 at busy count 20 -> next cycle muldiv_busy = 0, stall_cycles = 0.
  - With PERF_W = 4 and a 20-cycle stall -> stall_cycles = 15.
